// File: rtl/lvds_rx_pkg.sv
// Shared framer state encodings and DDR sync symbols for the LVDS I/Q receiver.
package lvds_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_I_PHASE = 2'd1,
    ST_Q_PHASE = 2'd2
  } framer_state_t;

  localparam logic [1:0] I_SYNC = 2'b10;
  localparam logic [1:0] Q_SYNC = 2'b01;

endpackage

// File: rtl/lvds_rx_lock_tracker.sv
// Good-frame counting, lock/overflow status and optional statistics counters.
// Statistics counters exist only when LVDS_RX_STATS_EN is defined.
module lvds_rx_lock_tracker #(
  parameter int LOCK_FRAMES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             i_ddr_clk,
  input  logic             i_rst_b,
  input  logic             frame_done,
  input  logic             sync_err,
  input  logic             resync,
  input  logic             fifo_full,
  output logic             push_ok,
  output logic             locked,
  output logic             overflow,
  output logic [CNT_W-1:0] sync_err_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_FRAMES);

  logic [GOOD_W-1:0] good, good_nx;
  logic              lock_nx, accept, drop;

  // Lock is judged on the post-update count so the frame that reaches
  // LOCK_FRAMES is itself pushed alongside the rising o_locked.
  always_comb begin
    good_nx = good;
    if (resync || sync_err)
      good_nx = '0;
    else if (frame_done && good != GOOD_MAX)
      good_nx = good + GOOD_W'(1);
    lock_nx = (good_nx == GOOD_MAX);
    accept  = frame_done && lock_nx;
    push_ok = accept && !fifo_full;
    drop    = accept && fifo_full;
  end

  always_ff @(posedge i_ddr_clk) begin
    if (!i_rst_b) begin
      good     <= '0;
      locked   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      good   <= good_nx;
      locked <= lock_nx;
      if (drop)
        overflow <= 1'b1;
    end
  end

`ifdef LVDS_RX_STATS_EN
  always_ff @(posedge i_ddr_clk) begin
    if (!i_rst_b) begin
      sync_err_cnt <= '0;
      drop_cnt     <= '0;
    end else begin
      if (sync_err && sync_err_cnt != '1)
        sync_err_cnt <= sync_err_cnt + CNT_W'(1);
      if (drop && drop_cnt != '1)
        drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end
`else
  assign sync_err_cnt = '0;
  assign drop_cnt     = '0;
`endif

endmodule

// File: rtl/lvds_rx_iq_framer.sv
// DDR LVDS I/Q frame aligner: hunts I/Q sync symbols, tracks lock and pushes
// whole frames downstream. Statistics counters enabled by LVDS_RX_STATS_EN.
module lvds_rx_iq_framer #(
  parameter  int SAMPLE_W    = 13,
  parameter  int LOCK_FRAMES = 4,
  parameter  int CNT_W       = 16,
  localparam int HALF_SYMS   = (SAMPLE_W + 3) / 2,
  localparam int FRAME_SYMS  = 2 * HALF_SYMS,
  localparam int FRAME_W     = 2 * FRAME_SYMS
) (
  input  logic               i_ddr_clk,
  input  logic               i_rst_b,
  input  logic [1:0]         i_ddr_data,
  input  logic               i_resync,
  input  logic               i_fifo_full,
  output logic               o_fifo_write_clk,
  output logic               o_fifo_push,
  output logic [FRAME_W-1:0] o_fifo_data,
  output logic               o_locked,
  output logic               o_overflow,
  output logic [CNT_W-1:0]   o_sync_err_cnt,
  output logic [CNT_W-1:0]   o_drop_cnt,
  output logic [1:0]         o_debug_state
);

  import lvds_rx_pkg::*;

  localparam int IDX_W = $clog2(FRAME_SYMS);
  localparam logic [IDX_W-1:0] IDX_HALF = IDX_W'(HALF_SYMS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_SYMS - 1);

  framer_state_t      state;
  logic [IDX_W-1:0]   idx;
  logic [FRAME_W-3:0] shreg;
  logic [FRAME_W-1:0] frame;
  logic               i_ok, q_ok, at_i, at_q;
  logic               frame_done, sync_err, push_ok;

  assign o_fifo_write_clk = i_ddr_clk;
  assign o_debug_state    = state;

  // I_PHASE at index 0 is the expected I sync of a back-to-back frame,
  // distinct from IDLE which only hunts.
  always_comb begin
    frame      = {shreg, i_ddr_data};
    i_ok       = (i_ddr_data == I_SYNC);
    q_ok       = (i_ddr_data == Q_SYNC);
    at_i       = (state == ST_I_PHASE) && (idx == '0);
    at_q       = (state == ST_I_PHASE) && (idx == IDX_HALF);
    frame_done = !i_resync && (state == ST_Q_PHASE) && (idx == IDX_LAST);
    sync_err   = !i_resync && ((at_i && !i_ok) || (at_q && !q_ok));
  end

  always_ff @(posedge i_ddr_clk) begin
    if (!i_rst_b) begin
      state       <= ST_IDLE;
      idx         <= '0;
      shreg       <= '0;
      o_fifo_push <= 1'b0;
      o_fifo_data <= '0;
    end else begin
      shreg       <= frame[FRAME_W-3:0];
      o_fifo_push <= push_ok;
      if (frame_done)
        o_fifo_data <= frame;
      if (i_resync) begin
        state <= ST_IDLE;
        idx   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_ok) begin
              state <= ST_I_PHASE;
              idx   <= IDX_W'(1);
            end else begin
              idx <= '0;
            end
          end
          ST_I_PHASE: begin
            if (sync_err) begin
              state <= ST_IDLE;
              idx   <= '0;
            end else begin
              if (at_q)
                state <= ST_Q_PHASE;
              idx <= idx + IDX_W'(1);
            end
          end
          ST_Q_PHASE: begin
            if (frame_done) begin
              state <= ST_I_PHASE;
              idx   <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          default: begin
            state <= ST_IDLE;
            idx   <= '0;
          end
        endcase
      end
    end
  end

  lvds_rx_lock_tracker #(
    .LOCK_FRAMES (LOCK_FRAMES),
    .CNT_W       (CNT_W)
  ) u_lock_tracker (
    .i_ddr_clk    (i_ddr_clk),
    .i_rst_b      (i_rst_b),
    .frame_done   (frame_done),
    .sync_err     (sync_err),
    .resync       (i_resync),
    .fifo_full    (i_fifo_full),
    .push_ok      (push_ok),
    .locked       (o_locked),
    .overflow     (o_overflow),
    .sync_err_cnt (o_sync_err_cnt),
    .drop_cnt     (o_drop_cnt)
  );

endmodule

// File: tb/tb_lvds_rx_iq_framer.sv
// Directed bench for lvds_rx_iq_framer: lock, sync loss, overflow, resync, reset, saturation.
module tb_lvds_rx_iq_framer;

`ifdef LVDS_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [12:0] I_S  = 13'h0ABC;
  localparam logic [12:0] Q_S  = 13'h1234;
  localparam logic [31:0] GOOD = 32'h9578_6468;

  logic        clk = 1'b0;
  logic        rst_b, resync, full;
  logic [1:0]  din;
  logic        wclk, push, locked, ovf;
  logic [31:0] data;
  logic [15:0] serr, drop;
  logic [1:0]  dbg;
  logic        wclk4, push4, locked4, ovf4;
  logic [31:0] data4;
  logic [3:0]  serr4, drop4;
  logic [1:0]  dbg4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lvds_rx_iq_framer dut (
    .i_ddr_clk(clk), .i_rst_b(rst_b), .i_ddr_data(din), .i_resync(resync),
    .i_fifo_full(full), .o_fifo_write_clk(wclk), .o_fifo_push(push),
    .o_fifo_data(data), .o_locked(locked), .o_overflow(ovf),
    .o_sync_err_cnt(serr), .o_drop_cnt(drop), .o_debug_state(dbg)
  );

  lvds_rx_iq_framer #(.CNT_W(4)) dut4 (
    .i_ddr_clk(clk), .i_rst_b(rst_b), .i_ddr_data(din), .i_resync(resync),
    .i_fifo_full(full), .o_fifo_write_clk(wclk4), .o_fifo_push(push4),
    .o_fifo_data(data4), .o_locked(locked4), .o_overflow(ovf4),
    .o_sync_err_cnt(serr4), .o_drop_cnt(drop4), .o_debug_state(dbg4)
  );

  function automatic logic [31:0] mk(input logic [12:0] i, input logic [12:0] q,
                                     input logic [1:0] qs);
    return {2'b10, i, 1'b0, qs, q, 1'b0};
  endfunction

  task automatic sym(input logic [1:0] s);
    din = s;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] f, input int probe, input bit full_last,
                            output bit pushed, output int stray, output bit probe_locked);
    stray = 0;
    pushed = 1'b0;
    probe_locked = 1'b0;
    for (int k = 0; k < 16; k++) begin
      full = full_last && (k == 15);
      sym(f[31-2*k -: 2]);
      if (k == probe) probe_locked = locked;
      if (k < 15) begin
        if (push) stray++;
      end else begin
        pushed = push;
      end
    end
    full = 1'b0;
  endtask

  task automatic test_reset;
    rst_b = 1'b0; resync = 1'b0; full = 1'b0; din = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (push !== 1'b0) begin errors++; $display("FAIL reset_push got %b want 0", push); end
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", data); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    checks++; if (serr !== 16'h0 || drop !== 16'h0) begin errors++; $display("FAIL reset_cnts got %h/%h want 0/0", serr, drop); end
    checks++; if (dbg !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dbg); end
    checks++; if (wclk !== clk) begin errors++; $display("FAIL write_clk got %b want %b", wclk, clk); end
    rst_b = 1'b1;
  endtask

  task automatic test_lock;
    bit p, pl; int st;
    for (int n = 1; n <= 6; n++) begin
      send_frame(mk(I_S, Q_S, 2'b01), -1, 1'b0, p, st, pl);
      checks++; if (p !== (n >= 4)) begin errors++; $display("FAIL lock_push frame %0d got %b want %b", n, p, n >= 4); end
      checks++; if (locked !== (n >= 4)) begin errors++; $display("FAIL lock_status frame %0d got %b want %b", n, locked, n >= 4); end
      checks++; if (st !== 0) begin errors++; $display("FAIL lock_stray frame %0d got %0d want 0", n, st); end
      if (n >= 4) begin
        checks++; if (data !== GOOD) begin errors++; $display("FAIL lock_data frame %0d got %h want %h", n, data, GOOD); end
      end
    end
    checks++; if (dbg !== 2'd1) begin errors++; $display("FAIL lock_state got %0d want 1", dbg); end
    checks++; if (serr !== 16'h0) begin errors++; $display("FAIL lock_serr got %0d want 0", serr); end
  endtask

  task automatic test_q_corrupt;
    bit p, pl; int st;
    send_frame(mk(I_S, 13'h0, 2'b11), 8, 1'b0, p, st, pl);
    checks++; if (pl !== 1'b0) begin errors++; $display("FAIL qerr_unlock_next got %b want 0", pl); end
    checks++; if (p !== 1'b0 || st !== 0) begin errors++; $display("FAIL qerr_push got %b/%0d want 0/0", p, st); end
    checks++; if (dbg !== 2'd0) begin errors++; $display("FAIL qerr_state got %0d want 0", dbg); end
    checks++; if (serr !== (STATS ? 16'd1 : 16'd0)) begin errors++; $display("FAIL qerr_serr got %0d want %0d", serr, STATS ? 1 : 0); end
    for (int n = 1; n <= 4; n++) begin
      send_frame(mk(I_S, Q_S, 2'b01), -1, 1'b0, p, st, pl);
      checks++; if (p !== (n == 4) || locked !== (n == 4)) begin errors++; $display("FAIL qerr_relock frame %0d got push %b lock %b want %b", n, p, locked, n == 4); end
    end
  endtask

  task automatic test_fifo_full;
    bit p, pl; int st;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL full_ovf_pre got %b want 0", ovf); end
    send_frame(mk(I_S, Q_S, 2'b01), -1, 1'b1, p, st, pl);
    checks++; if (p !== 1'b0) begin errors++; $display("FAIL full_push got %b want 0", p); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL full_ovf got %b want 1", ovf); end
    checks++; if (drop !== (STATS ? 16'd1 : 16'd0)) begin errors++; $display("FAIL full_drop got %0d want %0d", drop, STATS ? 1 : 0); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL full_locked got %b want 1", locked); end
    send_frame(mk(I_S, Q_S, 2'b01), -1, 1'b0, p, st, pl);
    checks++; if (p !== 1'b1 || data !== GOOD) begin errors++; $display("FAIL full_next got push %b data %h want 1 %h", p, data, GOOD); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL full_sticky got %b want 1", ovf); end
  endtask

  task automatic test_resync;
    logic [31:0] f;
    bit p, pl; int st;
    f = mk(I_S, Q_S, 2'b01);
    st = 0;
    for (int k = 0; k < 10; k++) sym(f[31-2*k -: 2]);
    resync = 1'b1;
    sym(f[31-20 -: 2]);
    resync = 1'b0;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL resync_unlock got %b want 0", locked); end
    checks++; if (dbg !== 2'd0) begin errors++; $display("FAIL resync_state got %0d want 0", dbg); end
    for (int k = 11; k < 16; k++) begin
      sym(2'b00);
      if (push) st++;
    end
    checks++; if (st !== 0) begin errors++; $display("FAIL resync_push got %0d want 0", st); end
    for (int n = 1; n <= 4; n++) begin
      send_frame(f, -1, 1'b0, p, st, pl);
      checks++; if (p !== (n == 4)) begin errors++; $display("FAIL resync_relock frame %0d got %b want %b", n, p, n == 4); end
    end
    for (int k = 0; k < 15; k++) sym(f[31-2*k -: 2]);
    resync = 1'b1;
    sym(f[1:0]);
    resync = 1'b0;
    checks++; if (push !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL resync_last got push %b lock %b want 0 0", push, locked); end
    send_frame(f, -1, 1'b0, p, st, pl);
    checks++; if (p !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL resync_after got push %b lock %b want 0 0", p, locked); end
    checks++; if (serr !== (STATS ? 16'd1 : 16'd0)) begin errors++; $display("FAIL resync_serr got %0d want %0d", serr, STATS ? 1 : 0); end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] f;
    bit p, pl; int st, pushes;
    f = mk(I_S, Q_S, 2'b01);
    for (int n = 1; n <= 3; n++) send_frame(f, -1, 1'b0, p, st, pl);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rstm_prelock got %b want 1", locked); end
    for (int k = 0; k < 5; k++) sym(f[31-2*k -: 2]);
    rst_b = 1'b0;
    sym(f[31-10 -: 2]);
    checks++; if (push !== 1'b0 || data !== 32'h0 || locked !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL rstm_outputs got push %b data %h lock %b ovf %b want 0", push, data, locked, ovf); end
    checks++; if (serr !== 16'h0 || drop !== 16'h0 || dbg !== 2'd0) begin
      errors++; $display("FAIL rstm_cnt_state got %h %h %0d want 0 0 0", serr, drop, dbg); end
    checks++; if (serr4 !== 4'h0 || drop4 !== 4'h0 || ovf4 !== 1'b0) begin
      errors++; $display("FAIL rstm_dut4 got %h %h %b want 0 0 0", serr4, drop4, ovf4); end
    rst_b = 1'b1;
    for (int k = 6; k < 16; k++) sym(2'b00);
    pushes = 0;
    for (int n = 0; n < 200; n++) begin
      send_frame(mk(I_S, 13'h0, 2'b11), -1, 1'b0, p, st, pl);
      pushes += st + int'(p) + int'(locked);
    end
    checks++; if (pushes !== 0) begin errors++; $display("FAIL sat_no_push got %0d want 0", pushes); end
    checks++; if (serr !== (STATS ? 16'd200 : 16'd0)) begin errors++; $display("FAIL sat_serr16 got %0d want %0d", serr, STATS ? 200 : 0); end
    checks++; if (serr4 !== (STATS ? 4'hF : 4'h0)) begin errors++; $display("FAIL sat_serr4 got %0d want %0d", serr4, STATS ? 15 : 0); end
    for (int n = 1; n <= 4; n++) begin
      send_frame(f, -1, 1'b0, p, st, pl);
      checks++; if (p !== (n == 4)) begin errors++; $display("FAIL rstm_relock frame %0d got %b want %b", n, p, n == 4); end
    end
    checks++; if (data !== GOOD || drop !== 16'h0) begin errors++; $display("FAIL rstm_final got %h drop %0d want %h 0", data, drop, GOOD); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_q_corrupt();
    test_fifo_full();
    test_resync();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lvds_rx_iq_framer.md
LVDS_RX_IQ_FRAMER -- requirements
Module: lvds_rx_iq_framer

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- SAMPLE_W, 13, I/Q sample width; SHALL be odd so each half-frame is a whole number of DDR symbols.
- LOCK_FRAMES, 4, consecutive good frames needed to declare lock (1..15).
- CNT_W, 16, width of the statistics counters.
REQ-002 Derived constants: HALF_SYMS = (SAMPLE_W+3)/2; FRAME_SYMS = 2*HALF_SYMS; FRAME_W = 2*FRAME_SYMS (32 at defaults).
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- i_ddr_clk, in, 1, the single clock; one 2-bit DDR symbol per rising edge.
- i_rst_b, in, 1, reset; synchronous and active-low.
- i_ddr_data, in, 2, deserialised symbol, MSB-first.
- i_resync, in, 1, one-cycle pulse forcing re-acquisition.
- i_fifo_full, in, 1, downstream FIFO full.
- o_fifo_write_clk, out, 1, equals i_ddr_clk.
- o_fifo_push, out, 1, one-cycle write strobe.
- o_fifo_data, out, FRAME_W, raw frame: I sync, I sample, pad, Q sync, Q sample, pad.
- o_locked, out, 1, frame lock status.
- o_overflow, out, 1, sticky flag: frame dropped while full.
- o_sync_err_cnt, out, CNT_W, sync error count.
- o_drop_cnt, out, CNT_W, dropped frame count.
- o_debug_state, out, 2, current framer state encoding.

Function
REQ-004 The I sync symbol SHALL be 2'b10 and the Q sync symbol 2'b01.
REQ-005 Every clock, i_ddr_data SHALL shift into the frame register LSB end: {reg[FRAME_W-3:0], i_ddr_data}.
REQ-006 The framer FSM SHALL have states IDLE (hunt), I_PHASE and Q_PHASE, with a symbol index 0..FRAME_SYMS-1.
REQ-007 IDLE: on an I sync symbol, go to I_PHASE with index=1; otherwise stay in IDLE.
REQ-008 I_PHASE: at index HALF_SYMS, a Q sync symbol goes to Q_PHASE; any other symbol goes to IDLE, clears the good-frame count and counts one sync error.
REQ-009 Q_PHASE: at index FRAME_SYMS-1, the frame is complete; the next symbol SHALL be checked as the I sync of the next frame (back-to-back frames with zero gap).
REQ-010 A complete frame SHALL increment the good-frame count, saturating at LOCK_FRAMES; o_locked SHALL rise the cycle after the count reaches LOCK_FRAMES.
REQ-011 While locked, a missing expected I sync or Q sync SHALL clear o_locked the next cycle, count one sync error and return the FSM to IDLE.
REQ-012 o_fifo_push SHALL assert exactly one cycle after the last symbol of a complete frame, only if o_locked=1 and i_fifo_full=0; o_fifo_data SHALL hold that whole frame in the same cycle.
REQ-013 A complete locked frame with i_fifo_full=1 SHALL be dropped, set o_overflow (sticky until reset) and increment o_drop_cnt.
REQ-014 Frames completed while unlocked SHALL NOT be pushed or counted as dropped.
REQ-015 i_resync=1 SHALL force IDLE, clear lock and the good-frame count, and suppress any push in that cycle; it takes priority over all other events.
REQ-016 Counters SHALL saturate at all-ones and never wrap.

Reset
REQ-017 When i_rst_b=0 on a rising edge, the block SHALL set: FSM=IDLE, index=0, o_fifo_push=0, o_fifo_data=0, o_locked=0, o_overflow=0, both counters=0, good-frame count=0.
REQ-018 Reset asserted mid-frame SHALL discard the partial frame; the first push after reset requires LOCK_FRAMES fresh good frames.

Configuration
REQ-019 With LVDS_RX_STATS_EN defined, o_sync_err_cnt and o_drop_cnt SHALL count as specified.
REQ-020 Without LVDS_RX_STATS_EN, both counters SHALL be constant 0 with no counter flops; o_overflow SHALL still operate.

Structure
REQ-021 Package lvds_rx_pkg SHALL hold the FSM state encodings and the I/Q sync symbol constants.
REQ-022 A sub-module lvds_rx_lock_tracker SHALL own the good-frame count, o_locked and the statistics counters; the framer FSM stays in the top level.

Verification
REQ-023 The bench SHALL cover:
- 6 clean frames at defaults (I=0x0ABC, Q=0x1234) -> o_locked rises after frame 4; frames 4..6 pushed; o_fifo_data = {2'b10,I,1'b0,2'b01,Q,1'b0}.
- Locked, Q sync corrupted to 2'b11 -> no push, o_locked=0, sync error count=1, relock after 4 good frames.
- Locked, i_fifo_full=1 over one frame end -> no push, o_overflow=1, o_drop_cnt=1, next frame pushed.
- i_resync pulse mid-frame while locked -> o_locked=0 next cycle, no push, state IDLE.
- i_rst_b low at symbol 5 -> all outputs 0; 200 corrupted frames with CNT_W=4 -> counter holds at 15.
